// File: rtl/isi_window_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isi_reader_pkg
// Description : Shared types and constants for the ISI window reader.
// Revision    : 1.0 - initial release
// ============================================================================
package isi_reader_pkg;

  localparam int ISI_COORD_WIDTH = 16;
  localparam int ISI_DECIM_W     = 2;

  typedef enum logic [0:0] {
    SEEK  = 1'b0,
    FRAME = 1'b1
  } state_e;

  // Window configuration held in shadow registers for the duration of a frame
  typedef struct packed {
    logic [ISI_COORD_WIDTH-1:0] col_start;
    logic [ISI_COORD_WIDTH-1:0] row_start;
    logic [ISI_COORD_WIDTH-1:0] width;
    logic [ISI_COORD_WIDTH-1:0] height;
    logic [ISI_DECIM_W-1:0]     decim;
  } window_cfg_t;

endpackage
`default_nettype wire

// File: rtl/isi_window_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : isi_window_reader_if
// Description : Output pixel stream of the ISI window reader (no backpressure).
// Revision    : 1.0 - initial release
// ============================================================================
interface isi_window_reader_if #(
  parameter int PIX_WIDTH   = 8,
  parameter int COORD_WIDTH = 16
);
  logic                   pix_valid_o;
  logic [PIX_WIDTH-1:0]   pix_o;
  logic [COORD_WIDTH-1:0] row_o;
  logic [COORD_WIDTH-1:0] col_o;
  logic                   sof_o;
  logic                   eol_o;
  logic                   eof_o;

  modport master (output pix_valid_o, pix_o, row_o, col_o, sof_o, eol_o, eof_o);
  modport slave  (input  pix_valid_o, pix_o, row_o, col_o, sof_o, eol_o, eof_o);
endinterface
`default_nettype wire

// File: rtl/isi_window_reader_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : isi_sync_edge
// Description : Input register plus delay register; level and rise/fall
//               strobes derived from the pair.
// Revision    : 1.0 - initial release
// ============================================================================
module isi_sync_edge #(
  parameter int WIDTH = 2
) (
  input  logic             pixclk_i,
  input  logic             reset_n_i,
  input  logic [WIDTH-1:0] sig_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  // Sample pins once, then keep a one-cycle-old copy for edge detection
  always_ff @(posedge pixclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= sig_i;
      s2_q <= s1_q;
    end
  end

  assign level_o = s1_q;
  assign rise_o  = s1_q & ~s2_q;
  assign fall_o  = ~s1_q & s2_q;
endmodule
`default_nettype wire

// File: rtl/isi_window_reader.sv
`default_nettype none
// ============================================================================
// Module      : isi_window_reader
// Description : ISI camera front end - row/col tracking, crop window with
//               power-of-two decimation, frame markers, frame counter and
//               line-length / truncation error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module isi_window_reader
  import isi_reader_pkg::*;
#(
  parameter int PIX_WIDTH      = 8,
  parameter int COORD_WIDTH    = ISI_COORD_WIDTH,
  parameter int MAX_DECIM_LOG2 = 2,
  localparam int DECIM_WIDTH   = $clog2(MAX_DECIM_LOG2 + 1)
) (
  input  logic                   pixclk_i,
  input  logic                   reset_n_i,
  input  logic [PIX_WIDTH-1:0]   pixel_data_i,
  input  logic                   hsync_i,
  input  logic                   vsync_i,
  input  logic [COORD_WIDTH-1:0] cfg_col_start_i,
  input  logic [COORD_WIDTH-1:0] cfg_row_start_i,
  input  logic [COORD_WIDTH-1:0] cfg_width_i,
  input  logic [COORD_WIDTH-1:0] cfg_height_i,
  input  logic [DECIM_WIDTH-1:0] cfg_decim_i,
  isi_window_reader_if.master    pix_if,
  output logic [15:0]            frame_cnt_o,
  output logic                   line_err_o,
  output logic                   trunc_err_o,
  output logic                   async_fifo_rst_o
);
  // bit 0 = hsync, bit 1 = vsync
  logic [1:0] sync_level, sync_rise, sync_fall;
  logic       unused_rise;
  logic       hs_level, hs_fall, vs_fall;

  isi_sync_edge #(.WIDTH(2)) u_sync (
    .pixclk_i  (pixclk_i),
    .reset_n_i (reset_n_i),
    .sig_i     ({vsync_i, hsync_i}),
    .level_o   (sync_level),
    .rise_o    (sync_rise),
    .fall_o    (sync_fall)
  );

  assign unused_rise = ^sync_rise;
  assign hs_level    = sync_level[0];
  assign hs_fall     = sync_fall[0];
  assign vs_fall     = sync_fall[1];

  state_e                 state_q;
  window_cfg_t            cfg_q, cfg_d;
  logic [PIX_WIDTH-1:0]   data_q;
  logic [COORD_WIDTH-1:0] row_q, col_q, ref_len_q;
  logic                   sof_done_q, eof_done_q;
  logic                   pix_valid_q, sof_q, eol_q, eof_q;
  logic [PIX_WIDTH-1:0]   pix_q;
  logic [COORD_WIDTH-1:0] row_out_q, col_out_q;
  logic                   line_err_q, trunc_err_q, fifo_rst_q;
  logic [15:0]            frame_cnt_q;

  logic [DECIM_WIDTH-1:0] decim_in, decim;
  logic [COORD_WIDTH-1:0] col_start, row_start, width, height;
  logic [COORD_WIDTH-1:0] step, mask, row_off, col_off;
  logic                   row_in, col_in, aligned, emit, is_eol, is_eof;

  // Oversized decimation requests saturate at the largest supported shift
  assign decim_in = (cfg_decim_i > DECIM_WIDTH'(MAX_DECIM_LOG2)) ?
                    DECIM_WIDTH'(MAX_DECIM_LOG2) : cfg_decim_i;
  assign cfg_d    = '{col_start: ISI_COORD_WIDTH'(cfg_col_start_i),
                      row_start: ISI_COORD_WIDTH'(cfg_row_start_i),
                      width:     ISI_COORD_WIDTH'(cfg_width_i),
                      height:    ISI_COORD_WIDTH'(cfg_height_i),
                      decim:     ISI_DECIM_W'(decim_in)};

  assign col_start = COORD_WIDTH'(cfg_q.col_start);
  assign row_start = COORD_WIDTH'(cfg_q.row_start);
  assign width     = COORD_WIDTH'(cfg_q.width);
  assign height    = COORD_WIDTH'(cfg_q.height);
  assign decim     = DECIM_WIDTH'(cfg_q.decim);

  // Window membership; end bounds use one extra bit so start+size never wraps
  always_comb begin
    step    = COORD_WIDTH'(1) << decim;
    mask    = step - COORD_WIDTH'(1);
    row_off = row_q - row_start;
    col_off = col_q - col_start;
    row_in  = ({1'b0, row_q} >= {1'b0, row_start}) &&
              ({1'b0, row_q} <  ({1'b0, row_start} + {1'b0, height}));
    col_in  = ({1'b0, col_q} >= {1'b0, col_start}) &&
              ({1'b0, col_q} <  ({1'b0, col_start} + {1'b0, width}));
    aligned = ((row_off & mask) == '0) && ((col_off & mask) == '0);
    emit    = (state_q == FRAME) && hs_level && !vs_fall && row_in && col_in && aligned;
    is_eol  = (col_off == (width - step));
    is_eof  = is_eol && (row_off == (height - step));
  end

  // Pixel data shares the sampling stage of the sync inputs
  always_ff @(posedge pixclk_i or negedge reset_n_i) begin
    if (!reset_n_i) data_q <= '0;
    else            data_q <= pixel_data_i;
  end

  // Frame FSM, position counters, line checking and registered outputs
  always_ff @(posedge pixclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= SEEK;
      cfg_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      ref_len_q   <= '0;
      sof_done_q  <= 1'b0;
      eof_done_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_q       <= '0;
      row_out_q   <= '0;
      col_out_q   <= '0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      line_err_q  <= 1'b0;
      trunc_err_q <= 1'b0;
      fifo_rst_q  <= 1'b1;
      frame_cnt_q <= '0;
    end else begin
      pix_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      line_err_q  <= 1'b0;
      trunc_err_q <= 1'b0;
      frame_cnt_q <= frame_cnt_q + 16'(eof_q);
      if (vs_fall) begin
        // A frame that started output but never reached its last pixel is cut short
        trunc_err_q <= (state_q == FRAME) && sof_done_q && !eof_done_q;
        state_q     <= FRAME;
        fifo_rst_q  <= 1'b0;
        cfg_q       <= cfg_d;
        row_q       <= '0;
        col_q       <= '0;
        ref_len_q   <= '0;
        sof_done_q  <= 1'b0;
        eof_done_q  <= 1'b0;
      end else if (state_q == FRAME) begin
        if (hs_level) begin
          col_q <= col_q + COORD_WIDTH'(1);
        end else if (hs_fall) begin
          row_q <= row_q + COORD_WIDTH'(1);
          col_q <= '0;
          // Lines are never empty, so a zero reference means "not yet captured"
          if (ref_len_q == '0) ref_len_q  <= col_q;
          else                 line_err_q <= (col_q != ref_len_q);
        end
        if (emit) begin
          pix_valid_q <= 1'b1;
          pix_q       <= data_q;
          row_out_q   <= row_off >> decim;
          col_out_q   <= col_off >> decim;
          sof_q       <= !sof_done_q;
          sof_done_q  <= 1'b1;
          eol_q       <= is_eol;
          eof_q       <= is_eof;
          if (is_eof) eof_done_q <= 1'b1;
        end
      end
    end
  end

  assign pix_if.pix_valid_o = pix_valid_q;
  assign pix_if.pix_o       = pix_q;
  assign pix_if.row_o       = row_out_q;
  assign pix_if.col_o       = col_out_q;
  assign pix_if.sof_o       = sof_q;
  assign pix_if.eol_o       = eol_q;
  assign pix_if.eof_o       = eof_q;
  assign frame_cnt_o        = frame_cnt_q;
  assign line_err_o         = line_err_q;
  assign trunc_err_o        = trunc_err_q;
  assign async_fifo_rst_o   = fifo_rst_q;
endmodule
`default_nettype wire

// File: tb/tb_isi_window_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_isi_window_reader
// Description : Scoreboard bench for isi_window_reader with a frame-level
//               reference model and randomized frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isi_window_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data;
  logic        hsync, vsync;
  logic [15:0] cs, rs, w, h;
  logic [1:0]  dec;
  logic [15:0] frame_cnt;
  logic        line_err, trunc_err, fifo_rst;

  always #5 clk = ~clk;

  isi_window_reader_if #(.PIX_WIDTH(8), .COORD_WIDTH(16)) pif ();

  isi_window_reader dut (
    .pixclk_i         (clk),
    .reset_n_i        (rst_n),
    .pixel_data_i     (data),
    .hsync_i          (hsync),
    .vsync_i          (vsync),
    .cfg_col_start_i  (cs),
    .cfg_row_start_i  (rs),
    .cfg_width_i      (w),
    .cfg_height_i     (h),
    .cfg_decim_i      (dec),
    .pix_if           (pif),
    .frame_cnt_o      (frame_cnt),
    .line_err_o       (line_err),
    .trunc_err_o      (trunc_err),
    .async_fifo_rst_o (fifo_rst)
  );

  typedef struct {
    logic [7:0] pix;
    int         row, col;
    bit         sof, eol, eof;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0, bad = 0;
  int   obs_line = 0, obs_trunc = 0;

  // Reference model state: frame-level view of the sensor stream
  int m_in_frame = 0, m_row = 0, m_sof = 0, m_eof = 0, m_ref = -1;
  int l_cs = 0, l_rs = 0, l_w = 0, l_h = 0, l_f = 1;
  int exp_frames = 0, exp_line = 0, exp_trunc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (pif.pix_valid_o) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_pixel actual row=%0d col=%0d required=no pixel",
                   pif.row_o, pif.col_o);
        end else begin
          e = sb.pop_front();
          if (pif.pix_o !== e.pix || pif.row_o !== 16'(e.row) || pif.col_o !== 16'(e.col) ||
              pif.sof_o !== e.sof || pif.eol_o !== e.eol || pif.eof_o !== e.eof || cyc != e.due) begin
            bad++;
            $display("FAIL pixel actual pix=%0h row=%0d col=%0d sof=%0b eol=%0b eof=%0b cyc=%0d required pix=%0h row=%0d col=%0d sof=%0b eol=%0b eof=%0b cyc=%0d",
                     pif.pix_o, pif.row_o, pif.col_o, pif.sof_o, pif.eol_o, pif.eof_o, cyc,
                     e.pix, e.row, e.col, e.sof, e.eol, e.eof, e.due);
          end
        end
      end
      if (line_err)  obs_line++;
      if (trunc_err) obs_trunc++;
    end
  endtask

  task automatic model_vsync_fall();
    if (m_in_frame != 0 && m_sof != 0 && m_eof == 0) exp_trunc++;
    m_in_frame = 1; m_row = 0; m_sof = 0; m_eof = 0; m_ref = -1;
    l_cs = int'(cs); l_rs = int'(rs); l_w = int'(w); l_h = int'(h);
    l_f  = 1 << ((dec > 2'd2) ? 2 : int'(dec));
  endtask

  task automatic model_pixel(input int c, input logic [7:0] d);
    exp_t e;
    int ro, co;
    if (m_in_frame == 0) return;
    ro = m_row - l_rs;
    co = c - l_cs;
    if (ro >= 0 && ro < l_h && co >= 0 && co < l_w && ro % l_f == 0 && co % l_f == 0) begin
      e.pix = d; e.row = ro / l_f; e.col = co / l_f;
      e.sof = (m_sof == 0);
      e.eol = (co == l_w - l_f);
      e.eof = e.eol && (ro == l_h - l_f);
      e.due = cyc + 2;
      m_sof = 1;
      if (e.eof) begin m_eof = 1; exp_frames++; end
      sb.push_back(e);
    end
  endtask

  task automatic model_line_end(input int len);
    if (m_in_frame == 0) return;
    if (m_ref < 0) m_ref = len;
    else if (len != m_ref) exp_line++;
    m_row++;
  endtask

  task automatic start_frame();
    @(negedge clk); vsync = 1'b1;
    repeat (2) @(negedge clk);
    vsync = 1'b0;
    model_vsync_fall();
    repeat (3) @(negedge clk);
  endtask

  task automatic drive_line(input int len);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      hsync = 1'b1;
      data  = 8'($urandom);
      model_pixel(c, data);
    end
    @(negedge clk); hsync = 1'b0;
    model_line_end(len);
    repeat (2) @(negedge clk);
  endtask

  task automatic end_frame_checks();
    repeat (6) @(negedge clk);
    check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("line_err_count", 32'(obs_line), 32'(exp_line));
    check("trunc_err_count", 32'(obs_trunc), 32'(exp_trunc));
    check("fifo_rst_after_frame", 32'(fifo_rst), 32'd0);
  endtask

  task automatic set_cfg(input int c0, input int r0, input int ww, input int hh, input int d);
    cs = 16'(c0); rs = 16'(r0); w = 16'(ww); h = 16'(hh); dec = 2'(d);
  endtask

  task automatic run_frame(input int rows, input int len, input int short_row, input int short_len);
    start_frame();
    for (int r = 0; r < rows; r++) drive_line((r == short_row) ? short_len : len);
    end_frame_checks();
  endtask

  initial begin
    fork
      monitor();
      begin
        #2000000;
        bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join_none

    rst_n = 1'b0; hsync = 1'b0; vsync = 1'b0; data = '0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("reset_pix_valid", 32'(pif.pix_valid_o), 32'd0);
    check("reset_fifo_rst", 32'(fifo_rst), 32'd1);
    check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    rst_n = 1'b1;

    // Lines with no frame start are ignored
    set_cfg(0, 0, 8, 8, 0);
    for (int i = 0; i < 3; i++) drive_line(10);
    check("seek_fifo_rst", 32'(fifo_rst), 32'd1);
    check("seek_frame_cnt", 32'(frame_cnt), 32'd0);

    // Basic crop, then decimation by 2, then one short line
    set_cfg(10, 10, 4, 2, 0);
    run_frame(16, 20, -1, 0);
    set_cfg(10, 10, 8, 4, 1);
    run_frame(16, 20, -1, 0);
    set_cfg(10, 10, 4, 2, 0);
    run_frame(16, 20, 2, 19);

    // Truncated frame with a mid-frame config change taking effect next frame
    set_cfg(2, 0, 4, 20, 0);
    start_frame();
    for (int r = 0; r < 12; r++) begin
      if (r == 5) set_cfg(0, 1, 6, 3, 0);
      drive_line(16);
    end
    end_frame_checks();
    run_frame(8, 16, -1, 0);

    // Randomized windows, decimation (incl. clamped shift 3) and line lengths
    for (int f = 0; f < 8; f++) begin
      int d, fac, len;
      d   = int'($urandom_range(0, 3));
      fac = 1 << ((d > 2) ? 2 : d);
      len = int'($urandom_range(12, 20));
      set_cfg(int'($urandom_range(0, 10)), int'($urandom_range(0, 6)),
              fac * int'($urandom_range(0, 4)), fac * int'($urandom_range(0, 3)), d);
      run_frame(int'($urandom_range(6, 12)), len,
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5)) : -1,
                len - int'($urandom_range(1, 3)));
    end

    // Reset in the middle of a line
    set_cfg(0, 0, 8, 2, 0);
    start_frame();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); hsync = 1'b1; data = 8'($urandom); model_pixel(c, data);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midreset_pix_valid", 32'(pif.pix_valid_o), 32'd0);
    check("midreset_fifo_rst", 32'(fifo_rst), 32'd1);
    check("midreset_frame_cnt", 32'(frame_cnt), 32'd0);
    hsync = 1'b0;
    sb.delete();
    m_in_frame = 0; m_sof = 0; m_eof = 0; exp_frames = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    set_cfg(0, 0, 4, 2, 0);
    for (int i = 0; i < 2; i++) drive_line(8);
    check("postreset_fifo_rst", 32'(fifo_rst), 32'd1);
    run_frame(4, 8, -1, 0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
